// File: rtl/cascade_scan_display_pkg.sv
// rtl/cascade_scan_display_pkg.sv - shared glyph table and direction codes for the display stage
package cascade_scan_display_pkg;

    // Segment order on the bus is {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/cascade_scan_display_seg7.sv
// rtl/cascade_scan_display_seg7.sv - combinational 4-bit hex to 7-segment glyph lookup
module seg7_hex_dec
    import cascade_scan_display_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/cascade_scan_display.sv
// rtl/cascade_scan_display.sv - cascaded upper digits behind the counter plus multiplexed 7-segment scan
module cascade_scan_display
    import cascade_scan_display_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int DIGIT_MOD = 10,
    parameter int SCAN_DIV  = 4
) (
    input  logic                      cp,
    input  logic                      clr,
    input  logic                      m,
    input  logic [3:0]                low_digit,
    input  logic                      cin,
    input  logic                      ovf_clr,
    output logic [4*(DIGITS-1)-1:0]   hi_digits,
    output logic                      ovf,
    output logic [6:0]                seg,
    output logic [DIGITS-1:0]         an
);

    localparam int HW = 4 * (DIGITS - 1);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = $clog2(DIGITS);

    localparam logic [3:0]    DMAX     = 4'(DIGIT_MOD - 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic          cin_q;
    logic          tick;
    logic [HW-1:0] hi_q;
    logic [HW-1:0] hi_nxt;
    logic          wrap;
    logic          carry;
    logic [3:0]    d;
    logic          ovf_q;
    logic [PW-1:0] pre;
    logic [IW-1:0] idx;
    logic [3:0]    scan_digit;
    logic [6:0]    glyph;
    logic [6:0]    seg_q;
    logic [DIGITS-1:0] an_q;

    assign tick = cin & ~cin_q;

    // Ripple through every upper digit in one cycle; whatever carry leaves the top digit is a wrap.
    always_comb begin
        hi_nxt = hi_q;
        carry  = tick;
        d      = 4'd0;
        for (int i = 0; i < DIGITS - 1; i++) begin
            d = hi_q[4*i +: 4];
            if (carry) begin
                if (m == DIR_UP) begin
                    if (d == DMAX) begin
                        d = 4'd0;
                    end else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = DMAX;
                    end else begin
                        d     = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            hi_nxt[4*i +: 4] = d;
        end
        wrap = carry;
    end

    always_comb begin
        scan_digit = low_digit;
        for (int i = 1; i < DIGITS; i++) begin
            if (idx == IW'(i)) begin
                scan_digit = hi_q[4*(i-1) +: 4];
            end
        end
    end

    seg7_hex_dec u_dec (
        .hex (scan_digit),
        .seg (glyph)
    );

    always_ff @(posedge cp or negedge clr) begin
        if (!clr) begin
            cin_q <= 1'b0;
            hi_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            cin_q <= cin;
            hi_q  <= hi_nxt;
            // A fresh wrap takes priority over a simultaneous clear request.
            if (wrap) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge cp or negedge clr) begin
        if (!clr) begin
            pre   <= '0;
            idx   <= '0;
            seg_q <= SEG_BLANK;
            an_q  <= '1;
        end else begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                pre <= pre + 1'b1;
            end
            an_q  <= ~(DIGITS'(1) << idx);
            seg_q <= glyph;
        end
    end

    assign hi_digits = hi_q;
    assign ovf       = ovf_q;
    assign seg       = seg_q;
    assign an        = an_q;

endmodule

// File: tb/tb_cascade_scan_display.sv
// tb/tb_cascade_scan_display.sv - directed self-checking bench for cascade_scan_display
module tb_cascade_scan_display;

    logic        cp;
    logic        clr;
    logic        m;
    logic [3:0]  low_digit;
    logic        cin;
    logic        ovf_clr;
    logic [11:0] hi_digits;
    logic        ovf;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [6:0] glyph_tb [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    cascade_scan_display #(.DIGITS(4), .DIGIT_MOD(10), .SCAN_DIV(4)) dut (
        .cp        (cp),
        .clr       (clr),
        .m         (m),
        .low_digit (low_digit),
        .cin       (cin),
        .ovf_clr   (ovf_clr),
        .hi_digits (hi_digits),
        .ovf       (ovf),
        .seg       (seg),
        .an        (an)
    );

    initial begin
        cp = 1'b0;
        forever #5 cp = ~cp;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick_clk();
        @(posedge cp);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        #2 clr = 1'b0;
        tick_clk();
        clr = 1'b1;
        cyc = 0;
    endtask

    task automatic pulse(input logic dir, input logic clr_ovf);
        m       = dir;
        ovf_clr = clr_ovf;
        cin     = 1'b1;
        tick_clk();
        cin     = 1'b0;
        ovf_clr = 1'b0;
        tick_clk();
    endtask

    task automatic test_reset();
        apply_reset();
        low_digit = 4'h5;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        n_checks++;
        if (hi_digits !== 12'h999 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: hi=%h ovf=%b expected hi=999 ovf=1", hi_digits, ovf);
        end
        #3 clr = 1'b0;
        #1;
        n_checks++;
        if (hi_digits !== 12'h000 || ovf !== 1'b0 || an !== 4'hF || seg !== 7'h00) begin
            n_fail++;
            $display("FAIL reset_async: hi=%h ovf=%b an=%h seg=%h expected 000 0 F 00",
                     hi_digits, ovf, an, seg);
        end
        tick_clk();
        n_checks++;
        if (hi_digits !== 12'h000 || an !== 4'hF || seg !== 7'h00) begin
            n_fail++;
            $display("FAIL reset_hold: hi=%h an=%h seg=%h expected 000 F 00", hi_digits, an, seg);
        end
        clr = 1'b1;
        cyc = 0;
        tick_clk();
        n_checks++;
        if (an !== 4'hE || seg !== glyph_tb[5]) begin
            n_fail++;
            $display("FAIL reset_first_edge: an=%h seg=%h expected an=E seg=%h", an, seg, glyph_tb[5]);
        end
    endtask

    task automatic test_up_cascade();
        apply_reset();
        for (int i = 0; i < 99; i++) pulse(1'b1, 1'b0);
        n_checks++;
        if (hi_digits !== 12'h099) begin
            n_fail++;
            $display("FAIL up_preload: hi=%h expected 099", hi_digits);
        end
        m   = 1'b1;
        cin = 1'b1;
        tick_clk();
        n_checks++;
        if (hi_digits !== 12'h100 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL up_cascade: hi=%h ovf=%b expected hi=100 ovf=0", hi_digits, ovf);
        end
        cin = 1'b0;
        tick_clk();
    endtask

    task automatic test_underflow();
        apply_reset();
        pulse(1'b0, 1'b0);
        n_checks++;
        if (hi_digits !== 12'h999 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow: hi=%h ovf=%b expected hi=999 ovf=1", hi_digits, ovf);
        end
        ovf_clr = 1'b1;
        tick_clk();
        ovf_clr = 1'b0;
        n_checks++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b expected 0", ovf);
        end
        pulse(1'b1, 1'b1);
        n_checks++;
        if (hi_digits !== 12'h000 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_set_wins: hi=%h ovf=%b expected hi=000 ovf=1", hi_digits, ovf);
        end
        pulse(1'b0, 1'b1);
        n_checks++;
        if (hi_digits !== 12'h999 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL underflow_set_wins: hi=%h ovf=%b expected hi=999 ovf=1", hi_digits, ovf);
        end
    endtask

    task automatic test_level_hold();
        apply_reset();
        m   = 1'b1;
        cin = 1'b1;
        for (int i = 0; i < 10; i++) tick_clk();
        cin = 1'b0;
        tick_clk();
        n_checks++;
        if (hi_digits !== 12'h001) begin
            n_fail++;
            $display("FAIL level_hold: hi=%h expected 001", hi_digits);
        end
        for (int i = 0; i < 6; i++) begin
            m = ~m;
            tick_clk();
        end
        n_checks++;
        if (hi_digits !== 12'h001 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL m_toggle: hi=%h ovf=%b expected hi=001 ovf=0", hi_digits, ovf);
        end
    endtask

    task automatic test_scan();
        logic [3:0] digs [4];
        logic [3:0] onehot;
        int         k;
        digs[0] = 4'hA;
        digs[1] = 4'h3;
        digs[2] = 4'h2;
        digs[3] = 4'h1;
        low_digit = 4'hA;
        apply_reset();
        for (int i = 0; i < 123; i++) pulse(1'b1, 1'b0);
        n_checks++;
        if (hi_digits !== 12'h123) begin
            n_fail++;
            $display("FAIL scan_preload: hi=%h expected 123", hi_digits);
        end
        for (int i = 0; i < 32; i++) begin
            tick_clk();
            k      = ((cyc - 1) / 4) % 4;
            onehot = 4'b0001 << k;
            n_checks++;
            if (an !== ~onehot || seg !== glyph_tb[digs[k]]) begin
                n_fail++;
                $display("FAIL scan cycle %0d: an=%h seg=%h expected an=%h seg=%h",
                         cyc, an, seg, ~onehot, glyph_tb[digs[k]]);
            end
        end
    endtask

    task automatic test_integration();
        logic [3:0]  q;
        logic [11:0] exp_hi;
        logic        prev;
        logic        cc;
        int          val;
        int          ticks;
        int          guard;
        apply_reset();
        q    = 4'd4;
        val  = 0;
        prev = 1'b0;
        for (int phase = 0; phase < 2; phase++) begin
            m     = (phase == 0);
            ticks = 0;
            guard = 0;
            while (ticks < 50 && guard < 1000) begin
                low_digit = q;
                cc        = m ? (q == 4'd9) : (q == 4'd0);
                cin       = cc;
                tick_clk();
                guard++;
                if (cc && !prev) begin
                    val    = m ? val + 1 : val - 1;
                    ticks++;
                    exp_hi = {4'(val / 100 % 10), 4'(val / 10 % 10), 4'(val % 10)};
                    n_checks++;
                    if (hi_digits !== exp_hi) begin
                        n_fail++;
                        $display("FAIL integ tick %0d phase %0d: hi=%h expected %h",
                                 ticks, phase, hi_digits, exp_hi);
                    end
                end
                prev = cc;
                if (m) q = (q == 4'd9) ? 4'd0 : q + 4'd1;
                else   q = (q == 4'd0) ? 4'd9 : q - 4'd1;
            end
            n_checks++;
            if (ticks != 50) begin
                n_fail++;
                $display("FAIL integ_budget phase %0d: ticks=%0d expected 50", phase, ticks);
            end
        end
        cin = 1'b0;
        tick_clk();
        n_checks++;
        if (hi_digits !== 12'h000 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL integ_final: hi=%h ovf=%b expected hi=000 ovf=0", hi_digits, ovf);
        end
    endtask

    initial begin
        clr       = 1'b0;
        m         = 1'b1;
        low_digit = 4'h0;
        cin       = 1'b0;
        ovf_clr   = 1'b0;
        #12;
        clr = 1'b1;
        test_reset();
        test_up_cascade();
        test_underflow();
        test_level_hold();
        test_scan();
        test_integration();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
